// File: rtl/inst_decode.sv
// ============================================================================
// inst_decode : RV32I decode stage with load-use hazard detection
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_decode (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] I_PC,
  input  logic [31:0] I_INST,
  input  logic        I_VALID,
  output logic        HAZARD,
  output logic        D_VALID,
  output logic [31:0] D_PC,
  output logic [6:0]  D_OPCODE,
  output logic [2:0]  D_FUNCT3,
  output logic [6:0]  D_FUNCT7,
  output logic [4:0]  D_RS1,
  output logic [4:0]  D_RS2,
  output logic [4:0]  D_RD,
  output logic [31:0] D_IMM,
  output logic        D_RD_WEN,
  output logic        D_MEM_RD,
  output logic        D_MEM_WR,
  output logic        D_BRANCH,
  output logic        D_JUMP,
  output logic        D_ILLEGAL
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rd_wen;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

  dec_t       dec_w;
  dec_t       dec_d;
  dec_t       dec_q;
  logic [6:0] opc_w;
  logic       use_rs1_w;
  logic       use_rs2_w;
  logic       use_rd_w;
  logic       legal_w;

  assign opc_w = I_INST[6:0];

  always_comb begin
    use_rs1_w = 1'b0;
    use_rs2_w = 1'b0;
    use_rd_w  = 1'b0;
    legal_w   = 1'b1;
    case (opc_w)
      OPC_LUI, OPC_AUIPC, OPC_JAL: use_rd_w = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        use_rs1_w = 1'b1;
        use_rd_w  = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        use_rs1_w = 1'b1;
        use_rs2_w = 1'b1;
      end
      OPC_OP: begin
        use_rs1_w = 1'b1;
        use_rs2_w = 1'b1;
        use_rd_w  = 1'b1;
      end
      OPC_MISC, OPC_SYSTEM: ;
      default: legal_w = 1'b0;
    endcase
  end

  // Full decode of the incoming word, independent of pipeline control.
  always_comb begin
    dec_w         = '0;
    dec_w.valid   = 1'b1;
    dec_w.pc      = I_PC;
    dec_w.opcode  = opc_w;
    dec_w.funct3  = I_INST[14:12];
    dec_w.funct7  = I_INST[31:25];
    dec_w.rs1     = use_rs1_w ? I_INST[19:15] : 5'd0;
    dec_w.rs2     = use_rs2_w ? I_INST[24:20] : 5'd0;
    dec_w.rd      = use_rd_w  ? I_INST[11:7]  : 5'd0;
    dec_w.rd_wen  = use_rd_w && (I_INST[11:7] != 5'd0);
    dec_w.mem_rd  = (opc_w == OPC_LOAD);
    dec_w.mem_wr  = (opc_w == OPC_STORE);
    dec_w.branch  = (opc_w == OPC_BRANCH);
    dec_w.jump    = (opc_w == OPC_JAL) || (opc_w == OPC_JALR);
    dec_w.illegal = !legal_w;
    case (opc_w)
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISC, OPC_SYSTEM:
        dec_w.imm = {{20{I_INST[31]}}, I_INST[31:20]};
      OPC_STORE:
        dec_w.imm = {{20{I_INST[31]}}, I_INST[31:25], I_INST[11:7]};
      OPC_BRANCH:
        dec_w.imm = {{19{I_INST[31]}}, I_INST[31], I_INST[7], I_INST[30:25], I_INST[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        dec_w.imm = {I_INST[31:12], 12'd0};
      OPC_JAL:
        dec_w.imm = {{11{I_INST[31]}}, I_INST[31], I_INST[19:12], I_INST[20], I_INST[30:21], 1'b0};
      default:
        dec_w.imm = 32'd0;
    endcase
  end

  assign HAZARD = dec_q.valid && dec_q.mem_rd && (dec_q.rd != 5'd0) && I_VALID &&
                  ((use_rs1_w && (I_INST[19:15] == dec_q.rd)) ||
                   (use_rs2_w && (I_INST[24:20] == dec_q.rd)));

  // Bubbles are all-zero so no stale control flag ever leaks downstream.
  always_comb begin
    dec_d = dec_q;
    if (FLUSH)
      dec_d = '0;
    else if (!STALL) begin
      if (HAZARD || !I_VALID)
        dec_d = '0;
      else
        dec_d = dec_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      dec_q <= '0;
    else
      dec_q <= dec_d;
  end

  assign D_VALID   = dec_q.valid;
  assign D_PC      = dec_q.pc;
  assign D_OPCODE  = dec_q.opcode;
  assign D_FUNCT3  = dec_q.funct3;
  assign D_FUNCT7  = dec_q.funct7;
  assign D_RS1     = dec_q.rs1;
  assign D_RS2     = dec_q.rs2;
  assign D_RD      = dec_q.rd;
  assign D_IMM     = dec_q.imm;
  assign D_RD_WEN  = dec_q.rd_wen;
  assign D_MEM_RD  = dec_q.mem_rd;
  assign D_MEM_WR  = dec_q.mem_wr;
  assign D_BRANCH  = dec_q.branch;
  assign D_JUMP    = dec_q.jump;
  assign D_ILLEGAL = dec_q.illegal;

endmodule

`default_nettype wire
